// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Writeback arbiter that merges bypassed ALU results and FIFO-buffered
//            memory/FPU results onto the register file's single write port.
// Options  : WB_X0_SUPPRESS_EN - a winning result targeting x0 completes its
//            handshake but never raises rf_write_enable.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_addr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          rf_write_enable,
  output logic [ADDR_W-1:0]             rf_write_addr,
  output logic [DATA_W-1:0]             rf_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

`ifdef WB_X0_SUPPRESS_EN
  localparam bit X0_SUPPRESS = 1'b1;
`else
  localparam bit X0_SUPPRESS = 1'b0;
`endif

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve;

  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_win;
  logic              alu_win;
  logic              push;
  logic              pop;
  logic              write_next;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // mem_ready is derived from the registered count only, so a pop in the
  // same cycle can never open the FIFO to a push.
  assign mem_ready  = (count != CNT_FULL);
  assign fifo_count = count;
  assign alu_ready  = alu_win;

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_FULL);
    fifo_win   = !fifo_empty && (fifo_full || !alu_valid || (starve >= STV_MAX));
    alu_win    = alu_valid && !fifo_win && !rst;
    push       = mem_valid && mem_ready;
    pop        = fifo_win;
    win_addr   = fifo_win ? fifo_addr[rd_ptr] : alu_addr;
    win_data   = fifo_win ? fifo_data[rd_ptr] : alu_data;
    write_next = (fifo_win || alu_win) && !(X0_SUPPRESS && (win_addr == '0));
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_addr[wr_ptr] <= mem_addr;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (fifo_empty || pop)
        starve <= '0;
      else if (alu_win && (starve < STV_MAX))
        starve <= starve + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= write_next;
      if (fifo_win || alu_win) begin
        rf_write_addr <= win_addr;
        rf_write_data <= win_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter using a queue-based reference
//            model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 3;
`ifdef WB_X0_SUPPRESS_EN
  localparam bit X0S = 1'b1;
`else
  localparam bit X0S = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [5:0]  alu_addr, mem_addr, rf_write_addr;
  logic [63:0] alu_data, mem_data, rf_write_data;
  logic        rf_write_enable;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [5:0]  a;
    logic [63:0] d;
  } ent_t;

  int          vectors = 0;
  int          miscompares = 0;
  ent_t        q[$];
  int          starve_m = 0;
  bit          known = 0;
  logic        e_en = 0;
  logic [5:0]  e_addr = 0;
  logic [63:0] e_data = 0;
  logic        last_ar = 0, last_mr = 0, obs_ar = 0;
  logic [5:0]  wlog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic r, input logic av, input logic [5:0] aa, input logic [63:0] ad,
                      input logic mv, input logic [5:0] ma, input logic [63:0] md);
    int   sz;
    bit   fw, ear, emr, win;
    ent_t w;
    logic [5:0]  wa;
    logic [63:0] wd;
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #2;
    sz  = q.size();
    fw  = (sz > 0) && (sz == DEPTH || !av || starve_m >= LIM);
    ear = av && !fw && !r;
    emr = (sz < DEPTH);
    obs_ar = alu_ready;
    check("alu_ready", alu_ready, ear);
    if (known) begin
      check("mem_ready", mem_ready, emr);
      check("fifo_count", fifo_count, sz);
      check("wr_enable", rf_write_enable, e_en);
      check("wr_addr", rf_write_addr, e_addr);
      check("wr_data", rf_write_data, e_data);
    end
    win = 0; wa = 0; wd = 0;
    if (r) begin
      q.delete(); starve_m = 0; e_en = 0; e_addr = 0; e_data = 0; known = 1;
    end else begin
      if (fw) begin
        w = q.pop_front(); wa = w.a; wd = w.d; win = 1;
      end else if (ear) begin
        wa = aa; wd = ad; win = 1;
      end
      if (win) begin
        e_en = !(X0S && wa == 0); e_addr = wa; e_data = wd;
      end else begin
        e_en = 0;
      end
      if (mv && emr) q.push_back('{a: ma, d: md});
      if (sz == 0 || fw) starve_m = 0;
      else if (ear && starve_m < LIM) starve_m++;
    end
    last_ar = ear;
    last_mr = emr && !r;
    @(posedge clk);
    #1;
    if (rf_write_enable && rf_write_addr >= 6'd32) wlog.push_back(rf_write_addr);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic        cav, cmv;
    logic [5:0]  caa, cma;
    logic [63:0] cad, cmd;
    bit          seen_full;
    int          mcnt;
    rst = 1; alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    @(posedge clk); #1;

    // Reset with the ALU requesting.
    step(1, 1, 6'd9, 64'h99, 0, 0, 0);
    step(1, 1, 6'd9, 64'h99, 0, 0, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_wr_enable", rf_write_enable, 0);

    // Single ALU result.
    step(0, 1, 6'd5, 64'hDEAD, 0, 0, 0);
    check("alu_wr_enable", rf_write_enable, 1);
    check("alu_wr_addr", rf_write_addr, 5);
    check("alu_wr_data", rf_write_data, 64'hDEAD);
    idle();
    check("alu_wr_enable_off", rf_write_enable, 0);

    // Starvation: four mem pushes with the ALU continuously valid.
    wlog.delete();
    for (int i = 0; i < 4; i++) step(0, 1, 6'd7, 64'h77, 1, 6'(33 + i), 64'(i + 1));
    for (int i = 0; i < 20; i++) step(0, 1, 6'd7, 64'h77, 0, 0, 0);
    check("starve_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) check("starve_order", wlog[i], 33 + i);
    idle();

    // Fill the FIFO while the ALU competes.
    seen_full = 0; mcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 6'd8, 64'h88, 1, 6'(40 + (mcnt % 8)), 64'(mcnt));
      if (last_mr) mcnt++;
      if (fifo_count == 3'd4) seen_full = 1;
    end
    check("fifo_full_seen", seen_full, 1);
    for (int i = 0; i < 8; i++) idle();
    check("drained", fifo_count, 0);

    // Reset with three buffered results.
    for (int i = 0; i < 3; i++) step(0, 1, 6'd8, 64'h88, 1, 6'(50 + i), 64'(i));
    check("pre_rst_count", fifo_count, 3);
    step(1, 0, 0, 0, 0, 0, 0);
    check("post_rst_count", fifo_count, 0);
    check("post_rst_wr_enable", rf_write_enable, 0);
    idle();
    check("post_rst_no_write", rf_write_enable, 0);

    // ALU write to x0.
    step(0, 1, 6'd0, 64'hFF, 0, 0, 0);
    check("x0_alu_ready", obs_ar, 1);
`ifdef WB_X0_SUPPRESS_EN
    check("x0_wr_enable", rf_write_enable, 0);
`else
    check("x0_wr_enable", rf_write_enable, 1);
    check("x0_wr_addr", rf_write_addr, 0);
`endif
    idle();

    // Randomized traffic with occasional resets.
    cav = 0; cmv = 0; caa = 0; cma = 0; cad = 0; cmd = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(cav && !last_ar)) begin
        cav = ($urandom_range(0, 3) != 0);
        caa = 6'($urandom);
        cad = {$urandom, $urandom};
      end
      if (!(cmv && !last_mr)) begin
        cmv = ($urandom_range(0, 3) != 0);
        cma = 6'($urandom);
        cmd = {$urandom, $urandom};
      end
      step(($urandom_range(0, 299) == 0), cav, caa, cad, cmv, cma, cmd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
